jtframe_ioctl2prog: RTL and testbench
=====================================

JTFRAME_IOCTL2PROG -- requirements
Module: jtframe_ioctl2prog

Interface
REQ-001 Parameter SDRAMW, default 22: width of prog_addr in 16-bit words.
REQ-002 Parameter BA1_START, default 25'h10_0000: first byte address mapped to SDRAM bank 1.
REQ-003 Parameter BA2_START, default 25'h20_0000: first byte address mapped to bank 2.
REQ-004 Parameter BA3_START, default 25'h30_0000: first byte address mapped to bank 3.
REQ-005 Parameter PROM_START, default 25'h40_0000: first byte address routed to PROM port; used only with the PROM macro.
REQ-006 Ports:
- clk_rom  in  1  sole clock.
- rst  in  1  reset, asynchronous, active-high.
- downloading  in  1  download window from the SPI controller.
- ioctl_addr  in  25  byte address.
- ioctl_data  in  8  byte data.
- ioctl_wr  in  1  one-cycle byte strobe.
- prog_addr  out  SDRAMW  word address, bank-relative.
- prog_data  out  16  byte replicated on both halves.
- prog_mask  out  2  active-low byte enable.
- prog_ba  out  2  bank.
- prog_we  out  1  write request.
- prog_rdy  in  1  SDRAM write accepted.
- prom_we  out  1  PROM byte strobe.
- dwnld_busy  out  1  busy to game/board.
- ovf  out  1  sticky overflow flag.

Function
REQ-007 Each ioctl_wr pushes {addr, data} into a 4-entry FIFO when downloading=1; strobes with downloading=0 are ignored.
REQ-008 Bank: addr<BA1_START→0, <BA2_START→1, <BA3_START→2, else 3; prog_addr = (addr − bank start)>>1, truncated to SDRAMW.
REQ-009 prog_mask = 2'b10 when addr[0]=0, 2'b01 when addr[0]=1; prog_data = {data,data}.
REQ-010 Head entry drives prog_* combinationally from FIFO registers; prog_we=1 whenever FIFO non-empty and head is SDRAM-bound.
REQ-011 prog_we && prog_rdy pops head in that cycle; prog_* stays stable while prog_we=1 and prog_rdy=0.
REQ-012 Latency: ioctl_wr at cycle n into empty FIFO gives prog_we=1 at n+1.
REQ-013 Simultaneous push and pop: both take effect, occupancy unchanged.
REQ-014 Push when full with no pop: entry dropped, ovf set to 1; ovf cleared only on the rising edge of downloading or by reset.
REQ-015 FSM IDLE→LOAD on rising downloading (FIFO flushed, ovf cleared).
REQ-016 FSM LOAD→TAIL when downloading=0.
REQ-017 FSM TAIL: waits for FIFO empty, then counts 16 cycles, then goes to IDLE; a rising downloading in TAIL goes to LOAD without flushing.
REQ-018 dwnld_busy = 1 in LOAD and TAIL, 0 in IDLE.
REQ-019 Wrap: pointers are 2-bit and wrap modulo 4; occupancy counter is 3-bit, range 0..4.

Reset
REQ-020 Reset asserted forces state IDLE, FIFO empty, counter 0, and drives prog_we, prom_we, ovf and dwnld_busy to 0; prog_addr, prog_data and prog_ba to 0; prog_mask to 2'b11.
REQ-021 Reset mid-download discards pending entries; operation resumes only on the next rising edge of downloading.

Configuration
REQ-022 With JTFRAME_DWNLD_PROM_EN defined, heads with addr≥PROM_START pop unconditionally one cycle with prom_we=1, never raise prog_we, and drive prog_addr = addr−PROM_START.
REQ-023 Without JTFRAME_DWNLD_PROM_EN, prom_we is tied to 0 and all addresses ≥BA3_START go to bank 3.

Structure
REQ-024 Package jtframe_dwnld_pkg holds the FIFO entry typedef (25-bit addr, 8-bit data), the FSM state enum and the TAIL_CYCLES=16 constant.
REQ-025 The FIFO is the sub-module jtframe_dwnld_fifo (depth 4, push/pop/full/empty); bank decode and FSM stay in the top module.

Verification
REQ-026 Write of 0x5A to addr 0x000003 with prog_rdy=1 -> prog_we for one cycle at n+1 with prog_addr=1, ba=0, mask=2'b01, data=0x5A5A.
REQ-027 Write of 0xC3 to addr 0x200004 with prog_rdy=0 for 5 cycles -> prog_addr=2, ba=2, mask=2'b10, outputs stable 5 cycles, popped on the 6th.
REQ-028 Six back-to-back strobes with prog_rdy=0 -> 4 entries kept, ovf=1; next download start clears ovf.
REQ-029 downloading falls with 2 entries pending and prog_rdy=1 -> dwnld_busy stays 1 for 2+16 cycles, then 0.
REQ-030 rst pulse with 3 entries pending -> prog_we=0 immediately, no writes after reset until a new downloading edge.
REQ-031 With JTFRAME_DWNLD_PROM_EN, write to addr 0x400010 -> prom_we pulse at n+1 with prog_addr=0x10 and no prog_we.

Source files
------------

// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the ioctl-to-SDRAM download path.
// FIFO entry layout, download FSM states and tail length.
package jtframe_dwnld_pkg;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } dwnld_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        TAIL = 2'd2
    } dwnld_state_t;

    localparam int TAIL_CYCLES = 16;

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Four-entry FIFO holding ioctl bytes until the SDRAM accepts them.
// Head entry is presented combinationally on dout.
module jtframe_dwnld_fifo
    import jtframe_dwnld_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  dwnld_entry_t din,
    output dwnld_entry_t dout,
    output logic         full,
    output logic         empty
);

    dwnld_entry_t mem [4];
    logic [1:0]   wr_ptr;
    logic [1:0]   rd_ptr;
    logic [2:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign full    = cnt == 3'd4;
    assign empty   = cnt == 3'd0;
    assign do_pop  = pop && !empty && !flush;
    // A pop frees the slot, so a full FIFO still accepts a push alongside it
    assign do_push = push && !flush && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/jtframe_ioctl2prog.sv
// Converts ioctl byte writes into SDRAM bank/word write requests.
// Define JTFRAME_DWNLD_PROM_EN to route addresses >= PROM_START to prom_we.
module jtframe_ioctl2prog
    import jtframe_dwnld_pkg::*;
#(
    parameter int          SDRAMW     = 22,
    parameter logic [24:0] BA1_START  = 25'h10_0000,
    parameter logic [24:0] BA2_START  = 25'h20_0000,
    parameter logic [24:0] BA3_START  = 25'h30_0000,
    parameter logic [24:0] PROM_START = 25'h40_0000
)(
    input  logic              clk_rom,
    input  logic              rst,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic [1:0]        prog_mask,
    output logic [1:0]        prog_ba,
    output logic              prog_we,
    input  logic              prog_rdy,
    output logic              prom_we,
    output logic              dwnld_busy,
    output logic              ovf
);

    dwnld_state_t state, nx_state;
    dwnld_entry_t din, head;
    logic         dl_last, rise, flush;
    logic         push, pop, full, empty;
    logic [4:0]   tail_cnt;
    logic         lt1, lt2, lt3, is_prom;
    logic [1:0]   bank;
    logic [24:0]  bank_start, offs;
    logic [SDRAMW-1:0] prom_addr;

    assign rise = downloading && !dl_last;
    assign din  = '{addr: ioctl_addr, data: ioctl_data};
    assign push = ioctl_wr && downloading && state != IDLE;
    assign pop  = (prog_we && prog_rdy) || prom_we;

    jtframe_dwnld_fifo u_fifo (
        .clk   (clk_rom),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Reset high so a download already in progress is not resumed
    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) dl_last <= 1'b1;
        else     dl_last <= downloading;
    end

    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst)                        ovf <= 1'b0;
        else if (rise)                  ovf <= 1'b0;
        else if (push && full && !pop)  ovf <= 1'b1;
    end

    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst)                         tail_cnt <= '0;
        else if (state != TAIL || !empty) tail_cnt <= '0;
        else                             tail_cnt <= tail_cnt + 5'd1;
    end

    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nx_state;
    end

    always_comb begin
        nx_state = state;
        case (state)
            IDLE: if (rise) nx_state = LOAD;
            LOAD: if (!downloading) nx_state = TAIL;
            TAIL: begin
                if (rise)
                    nx_state = LOAD;
                else if (empty && tail_cnt == 5'(TAIL_CYCLES - 1))
                    nx_state = IDLE;
            end
            default: nx_state = IDLE;
        endcase
    end

    always_comb begin
        dwnld_busy = state != IDLE;
        flush      = state == IDLE && rise;
    end

    always_comb begin
        lt1        = head.addr < BA1_START;
        lt2        = head.addr < BA2_START;
        lt3        = head.addr < BA3_START;
        bank       = 2'd0;
        bank_start = '0;
        unique case (1'b1)
            lt1: ;
            !lt1 && lt2: begin
                bank       = 2'd1;
                bank_start = BA1_START;
            end
            !lt2 && lt3: begin
                bank       = 2'd2;
                bank_start = BA2_START;
            end
            !lt3: begin
                bank       = 2'd3;
                bank_start = BA3_START;
            end
        endcase
        offs = head.addr - bank_start;
    end

`ifdef JTFRAME_DWNLD_PROM_EN
    assign is_prom   = head.addr >= PROM_START;
    assign prom_addr = SDRAMW'(head.addr - PROM_START);
`else
    logic unused_prom;
    assign unused_prom = ^PROM_START;
    assign is_prom     = 1'b0;
    assign prom_addr   = '0;
`endif

    always_comb begin
        prog_we   = 1'b0;
        prom_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_mask = 2'b11;
        prog_ba   = '0;
        if (!empty) begin
            prog_data = {head.data, head.data};
            prog_mask = head.addr[0] ? 2'b01 : 2'b10;
            if (is_prom) begin
                prom_we   = 1'b1;
                prog_addr = prom_addr;
            end else begin
                prog_we   = 1'b1;
                prog_addr = SDRAMW'(offs >> 1);
                prog_ba   = bank;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_ioctl2prog.sv
// Self-checking bench for jtframe_ioctl2prog with a write scoreboard.
module tb_jtframe_ioctl2prog;

    logic        clk_rom = 1'b0;
    logic        rst;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        prog_rdy;
    logic        prom_we;
    logic        dwnld_busy;
    logic        ovf;

    int ncmp = 0;
    int nerr = 0;

    typedef struct packed {
        logic [21:0] a;
        logic [1:0]  ba;
        logic [1:0]  m;
        logic [15:0] d;
    } exp_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [21:0] eaddr;
        logic [1:0]  eba;
        logic [1:0]  emask;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[9];

    jtframe_ioctl2prog dut (
        .clk_rom     (clk_rom),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_ba     (prog_ba),
        .prog_we     (prog_we),
        .prog_rdy    (prog_rdy),
        .prom_we     (prom_we),
        .dwnld_busy  (dwnld_busy),
        .ovf         (ovf)
    );

    always #5 clk_rom = ~clk_rom;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t low_bank(input logic [24:0] a,
                                      input logic [7:0] d);
        exp_t e;
        e.a  = 22'(a >> 1);
        e.ba = 2'd0;
        e.m  = a[0] ? 2'b01 : 2'b10;
        e.d  = {d, d};
        return e;
    endfunction

    // Strobe is driven for exactly one cycle; returns at posedge + 1
    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(posedge clk_rom); #1;
        ioctl_wr   = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_rom);
        #1;
    endtask

    always @(negedge clk_rom) begin
        if (!rst && prog_we && prog_rdy) begin
            if (sb.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_write: got addr %0h expected none",
                         prog_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(prog_addr), 32'(e.a));
                chk("wr_ba",   32'(prog_ba),   32'(e.ba));
                chk("wr_mask", 32'(prog_mask), 32'(e.m));
                chk("wr_data", 32'(prog_data), 32'(e.d));
            end
        end
`ifndef JTFRAME_DWNLD_PROM_EN
        if (!rst && prom_we) begin
            ncmp++;
            nerr++;
            $display("FAIL prom_we_default: got 1 expected 0");
        end
`endif
    end

    initial begin
        tbl[0] = '{25'h000003, 8'h5A, 22'h000001, 2'd0, 2'b01};
        tbl[1] = '{25'h000000, 8'h11, 22'h000000, 2'd0, 2'b10};
        tbl[2] = '{25'h0FFFFF, 8'h22, 22'h07FFFF, 2'd0, 2'b01};
        tbl[3] = '{25'h100000, 8'h33, 22'h000000, 2'd1, 2'b10};
        tbl[4] = '{25'h1FFFFF, 8'h44, 22'h07FFFF, 2'd1, 2'b01};
        tbl[5] = '{25'h200004, 8'h55, 22'h000002, 2'd2, 2'b10};
        tbl[6] = '{25'h300000, 8'h66, 22'h000000, 2'd3, 2'b10};
        tbl[7] = '{25'h3FFFFF, 8'h77, 22'h07FFFF, 2'd3, 2'b01};
        tbl[8] = '{25'h123456, 8'hA5, 22'h011A2B, 2'd1, 2'b10};

        rst = 1'b1;
        downloading = 1'b0;
        ioctl_addr = '0;
        ioctl_data = '0;
        ioctl_wr = 1'b0;
        prog_rdy = 1'b1;
        cycles(3);
        chk("rst_prog_we",   32'(prog_we),    0);
        chk("rst_prom_we",   32'(prom_we),    0);
        chk("rst_ovf",       32'(ovf),        0);
        chk("rst_busy",      32'(dwnld_busy), 0);
        chk("rst_prog_addr", 32'(prog_addr),  0);
        chk("rst_prog_data", 32'(prog_data),  0);
        chk("rst_prog_ba",   32'(prog_ba),    0);
        chk("rst_prog_mask", 32'(prog_mask),  32'h3);
        rst = 1'b0;
        cycles(1);

        downloading = 1'b1;
        cycles(1);
        @(negedge clk_rom);
        chk("busy_load", 32'(dwnld_busy), 1);
        @(posedge clk_rom); #1;

        // Basic decode and latency with an always-ready SDRAM
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{tbl[i].eaddr, tbl[i].eba, tbl[i].emask,
                           {tbl[i].data, tbl[i].data}});
            ioctl_addr = tbl[i].addr;
            ioctl_data = tbl[i].data;
            ioctl_wr   = 1'b1;
            @(negedge clk_rom);
            chk("pre_we", 32'(prog_we), 0);
            @(posedge clk_rom); #1;
            ioctl_wr = 1'b0;
            @(negedge clk_rom);
            chk("lat_we", 32'(prog_we), 1);
            @(posedge clk_rom); #1;
            @(negedge clk_rom);
            chk("one_cycle_we", 32'(prog_we), 0);
            @(posedge clk_rom); #1;
        end

        // Held head while SDRAM is busy
        prog_rdy = 1'b0;
        sb.push_back('{22'h2, 2'd2, 2'b10, 16'hC3C3});
        strobe(25'h200004, 8'hC3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_rom);
            chk("hold_we",   32'(prog_we),   1);
            chk("hold_addr", 32'(prog_addr), 2);
            chk("hold_ba",   32'(prog_ba),   2);
            chk("hold_mask", 32'(prog_mask), 2);
            chk("hold_data", 32'(prog_data), 32'hC3C3);
            @(posedge clk_rom); #1;
        end
        prog_rdy = 1'b1;
        @(posedge clk_rom); #1;
        prog_rdy = 1'b0;
        @(negedge clk_rom);
        chk("hold_popped", 32'(prog_we), 0);
        chk("hold_sb", 32'(sb.size()), 0);
        @(posedge clk_rom); #1;

        // Overflow: six strobes into a stalled FIFO
        for (int i = 0; i < 6; i++) begin
            logic [24:0] a;
            a = 25'h10 + 25'(i);
            if (i < 4) sb.push_back(low_bank(a, 8'h60 + 8'(i)));
            ioctl_addr = a;
            ioctl_data = 8'h60 + 8'(i);
            ioctl_wr   = 1'b1;
            @(posedge clk_rom); #1;
        end
        ioctl_wr = 1'b0;
        @(negedge clk_rom);
        chk("ovf_set", 32'(ovf), 1);
        @(posedge clk_rom); #1;
        prog_rdy = 1'b1;
        cycles(6);
        chk("ovf_kept4", 32'(sb.size()), 0);
        @(negedge clk_rom);
        chk("ovf_drained", 32'(prog_we), 0);
        chk("ovf_sticky", 32'(ovf), 1);
        @(posedge clk_rom); #1;
        downloading = 1'b0;
        begin
            int n;
            n = 0;
            while (dwnld_busy && n < 40) begin
                @(posedge clk_rom); #1;
                n++;
            end
            chk("busy_timeout", 32'(dwnld_busy), 0);
        end
        chk("ovf_idle", 32'(ovf), 1);
        downloading = 1'b1;
        cycles(1);
        @(negedge clk_rom);
        chk("ovf_clear", 32'(ovf), 0);
        @(posedge clk_rom); #1;

        // Tail: two entries pending when the download ends
        prog_rdy = 1'b0;
        sb.push_back(low_bank(25'h20, 8'h81));
        strobe(25'h20, 8'h81);
        sb.push_back(low_bank(25'h21, 8'h82));
        strobe(25'h21, 8'h82);
        downloading = 1'b0;
        prog_rdy = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk_rom);
            @(negedge clk_rom);
            if (k == 17) chk("tail_busy17", 32'(dwnld_busy), 1);
            if (k == 18) chk("tail_idle18", 32'(dwnld_busy), 0);
        end
        chk("tail_sb", 32'(sb.size()), 0);
        @(posedge clk_rom); #1;

        // Reset with three entries pending
        downloading = 1'b1;
        cycles(2);
        prog_rdy = 1'b0;
        strobe(25'h40, 8'h91);
        strobe(25'h41, 8'h92);
        strobe(25'h42, 8'h93);
        @(negedge clk_rom);
        chk("pre_rst_we", 32'(prog_we), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_we", 32'(prog_we), 0);
        chk("rst_async_busy", 32'(dwnld_busy), 0);
        @(posedge clk_rom); #1;
        rst = 1'b0;
        prog_rdy = 1'b1;
        strobe(25'h30, 8'h66);
        @(negedge clk_rom);
        chk("post_rst_ignored", 32'(prog_we), 0);
        cycles(3);
        chk("post_rst_busy", 32'(dwnld_busy), 0);
        downloading = 1'b0;
        cycles(2);
        downloading = 1'b1;
        cycles(2);
        sb.push_back(low_bank(25'h31, 8'h77));
        strobe(25'h31, 8'h77);
        @(negedge clk_rom);
        chk("resume_we", 32'(prog_we), 1);
        @(posedge clk_rom); #1;

`ifdef JTFRAME_DWNLD_PROM_EN
        strobe(25'h400010, 8'hEE);
        @(negedge clk_rom);
        chk("prom_we",      32'(prom_we),   1);
        chk("prom_addr",    32'(prog_addr), 32'h10);
        chk("prom_prog_we", 32'(prog_we),   0);
        @(posedge clk_rom); #1;
        @(negedge clk_rom);
        chk("prom_pulse", 32'(prom_we), 0);
        @(posedge clk_rom); #1;
`endif

        cycles(4);
        chk("final_sb", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
